// File: rtl/pixel_fill_writer.sv
// pixel_fill_writer
//   Write-side engine for the 8bpp pixel plane VRAM. Accepts rectangle-fill
//   commands over a valid/ready handshake. Each rectangle is clipped to the
//   screen, then written one pixel per cycle at addr = y*H_RES + x.
//
// Ports
//   clk        : system clock (only clock)
//   reset_n    : synchronous, active-low reset
//   cmd_valid  : command present
//   cmd_ready  : engine idle and able to accept a command
//   cmd_x/y    : top-left corner (unclipped)
//   cmd_w/h    : size in pixels / lines
//   cmd_color  : RRRGGGBB fill value
//   vram_stall : write port unavailable this cycle; current write is held
//   vram_addr  : write address
//   vram_d     : write data
//   vram_we    : write enable
//   busy       : command in progress (CLIP or FILL)
//   done       : one-cycle pulse at command completion
module pixel_fill_writer #(
  parameter int H_RES  = 320,
  parameter int V_RES  = 240,
  parameter int ADDR_W = 17
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [8:0]        cmd_x,
  input  logic [7:0]        cmd_y,
  input  logic [8:0]        cmd_w,
  input  logic [7:0]        cmd_h,
  input  logic [7:0]        cmd_color,
  input  logic              vram_stall,
  output logic [ADDR_W-1:0] vram_addr,
  output logic [7:0]        vram_d,
  output logic              vram_we,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CLIP = 2'd1,
    ST_FILL = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [9:0]        H_RES_W  = 10'(H_RES);
  localparam logic [9:0]        V_RES_W  = 10'(V_RES);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(H_RES);

  state_t              state_q, state_d;
  logic [8:0]          x_q, x_d;
  logic [7:0]          y_q, y_d;
  logic [8:0]          w_q, w_d;
  logic [7:0]          h_q, h_d;
  logic [7:0]          color_q, color_d;
  logic [9:0]          xe_q, xe_d;
  logic [9:0]          ye_q, ye_d;
  logic [9:0]          col_q, col_d;
  logic [9:0]          row_q, row_d;
  logic [ADDR_W-1:0]   row_base_q, row_base_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          data_q, data_d;
  logic                we_q, we_d;

  // Clip arithmetic: 10 bits holds x+w (<=1022) and y+h (<=510) without overflow.
  logic [9:0]          xe_sum, ye_sum;
  logic [9:0]          col_inc, row_inc;
  logic                empty;
  logic [ADDR_W-1:0]   y_base;

  always_comb begin
    xe_sum  = {1'b0, x_q} + {1'b0, w_q};
    ye_sum  = {2'b00, y_q} + {2'b00, h_q};
    empty   = ({1'b0, x_q} >= H_RES_W) || ({2'b00, y_q} >= V_RES_W) ||
              (w_q == 9'd0) || (h_q == 8'd0);
    // Only multiply in the design: once per command, never in the pixel loop.
    y_base  = ADDR_W'(y_q) * STRIDE_A;
    col_inc = col_q + 10'd1;
    row_inc = row_q + 10'd1;

    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    w_d        = w_q;
    h_d        = h_q;
    color_d    = color_q;
    xe_d       = xe_q;
    ye_d       = ye_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    addr_d     = addr_q;
    data_d     = data_q;
    we_d       = we_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          x_d     = cmd_x;
          y_d     = cmd_y;
          w_d     = cmd_w;
          h_d     = cmd_h;
          color_d = cmd_color;
          state_d = ST_CLIP;
        end
      end

      ST_CLIP: begin
        xe_d = (xe_sum > H_RES_W) ? H_RES_W : xe_sum;
        ye_d = (ye_sum > V_RES_W) ? V_RES_W : ye_sum;
        if (empty) begin
          state_d = ST_DONE;
        end else begin
          state_d    = ST_FILL;
          col_d      = {1'b0, x_q};
          row_d      = {2'b00, y_q};
          row_base_d = y_base;
          addr_d     = y_base + ADDR_W'(x_q);
          data_d     = color_q;
          we_d       = 1'b1;
        end
      end

      ST_FILL: begin
        // A stalled cycle leaves every register untouched, holding the write.
        if (!vram_stall) begin
          if (col_inc == xe_q) begin
            if (row_inc == ye_q) begin
              we_d    = 1'b0;
              state_d = ST_DONE;
            end else begin
              col_d      = {1'b0, x_q};
              row_d      = row_inc;
              row_base_d = row_base_q + STRIDE_A;
              addr_d     = row_base_q + STRIDE_A + ADDR_W'(x_q);
            end
          end else begin
            col_d  = col_inc;
            addr_d = addr_q + ADDR_W'(1);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      w_q        <= '0;
      h_q        <= '0;
      color_q    <= '0;
      xe_q       <= '0;
      ye_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      w_q        <= w_d;
      h_q        <= h_d;
      color_q    <= color_d;
      xe_q       <= xe_d;
      ye_q       <= ye_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      we_q       <= we_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_CLIP) || (state_q == ST_FILL);
  assign done      = (state_q == ST_DONE);
  assign vram_addr = addr_q;
  assign vram_d    = data_q;
  assign vram_we   = we_q;

endmodule
